// File: rtl/status_flags_unit_pkg.sv
// Shared definitions for the NZCV status-flag pipeline: flag indices, slot type and
// forwarding-source encodings.
package status_flags_unit_pkg;

    localparam int unsigned FLAGS_WIDTH = 4;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef struct packed {
        logic                   wr;
        logic [FLAGS_WIDTH-1:0] flags;
    } flag_slot_t;

    typedef enum logic [1:0] {
        SrcCommit = 2'b00,
        SrcWb     = 2'b01,
        SrcMem    = 2'b10,
        SrcExe    = 2'b11
    } fwd_src_t;

endpackage

// File: rtl/status_flags_unit_slot.sv
// One pipeline slot carrying a pending flag update; holds while frozen.
module flag_slot
    import status_flags_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       freeze,
    input  flag_slot_t d,
    output flag_slot_t q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (!freeze) begin
            q <= d;
        end
    end

endmodule

// File: rtl/status_flags_unit.sv
// Architectural NZCV register with in-flight MEM/WB flag updates and a youngest-first
// forwarded view for condition evaluation in ID.
module status_flags_unit
    import status_flags_unit_pkg::*;
#(
    parameter int unsigned FLAG_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              exe_valid,
    input  logic              exe_s,
    input  logic              exe_cond_pass,
    input  logic [FLAG_W-1:0] alu_status,
    output logic [FLAG_W-1:0] status_regs,
    output logic [FLAG_W-1:0] status_fwd,
    output logic [1:0]        pending_cnt,
    output logic [1:0]        fwd_src
);

    logic              exe_wr;
    flag_slot_t        exe_slot;
    flag_slot_t        mem_slot;
    flag_slot_t        wb_slot;
    logic [FLAG_W-1:0] regs_q;
    logic [1:0]        cnt_q;
    fwd_src_t          src;

    assign exe_wr   = exe_valid & exe_s & exe_cond_pass;
    assign exe_slot = '{wr: exe_wr, flags: alu_status};

    flag_slot u_mem_slot (
        .clk    (clk),
        .rst    (rst),
        .freeze (freeze),
        .d      (exe_slot),
        .q      (mem_slot)
    );

    flag_slot u_wb_slot (
        .clk    (clk),
        .rst    (rst),
        .freeze (freeze),
        .d      (mem_slot),
        .q      (wb_slot)
    );

    // The count tracks what the slots will hold after this edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs_q <= '0;
            cnt_q  <= '0;
        end else if (!freeze) begin
            if (wb_slot.wr) begin
                regs_q <= wb_slot.flags;
            end
            cnt_q <= {1'b0, exe_wr} + {1'b0, mem_slot.wr};
        end
    end

    // Slot flags with wr=0 are stale and must never be selected.
    always_comb begin
        status_fwd = regs_q;
        src        = SrcCommit;
        if (exe_wr) begin
            status_fwd = alu_status;
            src        = SrcExe;
        end else if (mem_slot.wr) begin
            status_fwd = mem_slot.flags;
            src        = SrcMem;
        end else if (wb_slot.wr) begin
            status_fwd = wb_slot.flags;
            src        = SrcWb;
        end
    end

    assign status_regs = regs_q;
    assign pending_cnt = cnt_q;
    assign fwd_src     = src;

endmodule
